seq_mul16: RTL
==============

Name: seq_mul16

Overview:
- Sequential shift-and-add multiplier that consumes the team's 16-bit carry-lookahead adder.
- Each cycle it drives the adder with a partial-product half and the multiplicand, then registers the sum and carry.
- Produces a 2W-bit product after W iterations.
- Sits downstream of the operand source and upstream of the result consumer, using a valid/ready handshake on both sides.

Parameters:
- W, 16, operand width. Only 16 is supported by the adder sub-module; elaboration error otherwise.

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b valid.
- in_ready  output  1  block accepts operands.
- a  input  W  multiplicand.
- b  input  W  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- p  output  2W  product {hi, lo}.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset: nrst low asynchronously forces state=IDLE, count=0, hi=0, lo=0, mcand=0, c=0. Outputs: in_ready=1, out_valid=0, busy=0, p=0.
- Reset mid-operation aborts the product silently; no partial output.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid && in_ready: mcand<=a, lo<=b, hi<=0, count<=0; go to BUSY.
  - No acceptance means no register change.
- BUSY, one iteration per cycle, in_ready=0, busy=1:
  - Adder input: hi + (lo[0] ? mcand : 0), carry-in 0, giving {cout, sum}.
  - Register {hi, lo} <= {cout, sum, lo[W-1:1]} (33-bit right shift by 1).
  - count<=count+1.
  - When count==W-1 on the iteration edge, go to DONE.
- DONE:
  - out_valid=1; p={hi, lo}, stable while out_valid && !out_ready.
  - On out_valid && out_ready: go to IDLE; p keeps its value, out_valid falls.
- Latency: operands accepted at edge k; out_valid is high after edge k+W (W=16 gives 16 cycles).
- Throughput: one product per W+2 cycles minimum (accept, W iterations, hand off).
- in_ready is combinational from state only (IDLE); never depends on in_valid.
- out_ready held low: DONE persists indefinitely; in_ready stays 0 (back-pressure).
- in_valid while not IDLE is ignored; a and b are not sampled.
- Arithmetic: unsigned by default. Exact 2W-bit result; no overflow possible; carry out of the adder is never dropped.
- count is ceil(log2 W)+1 bits wide and must not wrap before the DONE transition.

Optional Feature:
- Macro: SEQ_MUL16_SIGNED_EN.
- Defined: a and b are two's complement and p is the signed 2W-bit product.
  - Iterations 0..W-2 add mcand when lo[0]=1.
  - The final iteration (count==W-1) subtracts mcand when lo[0]=1: adder input ~mcand, carry-in 1.
  - Every shift is arithmetic: the shifted-in MSB is sum[W-1] XOR overflow, not cout.
- Undefined: unsigned behaviour as above; the adder carry-in is tied 0.
- Latency and handshake are identical in both builds.

Decomposition:
- Package seq_mul_pkg holds:
  - the constant MUL_W=16;
  - the state enum typedef mul_state_t {IDLE, BUSY, DONE};
  - the count width constant.
- One natural sub-module: cla_add16, a 16-bit carry-lookahead adder.
  - Built from four 4-bit group-generate/propagate blocks plus group-carry lookahead.
  - Adds carry-in and carry-out relative to the existing adder.
  - Purely combinational; instantiated once.
- The FSM and datapath registers stay in seq_mul16.

Test Plan:
- Reset: nrst low mid-BUSY (e.g. cycle 7 of 0x1234*0x5678) -> immediately out_valid=0, in_ready=1, p=0. Next operation 3*5 -> p=0x0000000F.
- Basic unsigned: a=0x1234, b=0x5678 accepted at edge k -> out_valid high after edge k+16, p=0x06260060.
- Carry stress: a=0xFFFF, b=0xFFFF -> p=0xFFFE0001; a=0, b=0xFFFF -> p=0; a=1, b=0x8000 -> p=0x00008000.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> p stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next edge, then accepts new operands.
- Back-to-back: in_valid held high with a stream of 4 random operand pairs, out_ready=1 -> each product correct vs reference model, spacing exactly W+2 cycles.
- SEQ_MUL16_SIGNED_EN build: a=0xFFFF(-1), b=0x0003 -> p=0xFFFFFFFD; a=0x8000, b=0x8000 -> p=0x40000000; a=0x7FFF, b=0x8000 -> p=0xC0008000.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared constants and state type for the sequential 16-bit multiplier.
package seq_mul_pkg;

    localparam int MUL_W = 16;
    localparam int CNT_W = $clog2(MUL_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/seq_mul16_cla_add16.sv
// 16-bit carry-lookahead adder: four 4-bit generate/propagate groups joined
// by a group-level carry lookahead unit. Purely combinational.
module cla_add16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] t;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = x & y;
    assign t = x ^ y;

    for (genvar i = 0; i < 4; i++) begin : g_grp
        localparam int B = 4 * i;

        assign gg[i] = g[B+3]
                     | (t[B+3] & g[B+2])
                     | (t[B+3] & t[B+2] & g[B+1])
                     | (t[B+3] & t[B+2] & t[B+1] & g[B]);
        assign gp[i] = &t[B+3:B];

        assign c[B]   = gc[i];
        assign c[B+1] = g[B] | (t[B] & gc[i]);
        assign c[B+2] = g[B+1] | (t[B+1] & g[B]) | (t[B+1] & t[B] & gc[i]);
        assign c[B+3] = g[B+2] | (t[B+2] & g[B+1]) | (t[B+2] & t[B+1] & g[B])
                      | (t[B+2] & t[B+1] & t[B] & gc[i]);
    end

    // Group carries are fully expanded from cin so no group waits on another.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    assign sum  = t ^ c;
    assign cout = gc[4];

endmodule

// File: rtl/seq_mul16.sv
// Shift-and-add multiplier with valid/ready on both sides; W iterations per product.
// Define SEQ_MUL16_SIGNED_EN for two's complement operands (Baugh-free signed shift-add).
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   BUSY  | one add/shift iteration per cycle, W cycles
//   DONE  | product held on p until the consumer takes it
module seq_mul16
    import seq_mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    if (W != MUL_W) begin : g_bad_w
        $error("seq_mul16: the cla_add16 datapath only supports W=16");
    end

    mul_state_t        state;
    logic [CNT_W-1:0]  count;
    logic [W-1:0]      hi;
    logic [W-1:0]      lo;
    logic [W-1:0]      mcand;

    logic              last;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic [W-1:0]      sum;
    logic              cout;
    logic              shift_msb;

    assign last = (count == CNT_W'(W - 1));

`ifdef SEQ_MUL16_SIGNED_EN
    logic ovf;

    // The multiplier's sign bit carries weight -2^(W-1), so the last step subtracts.
    assign add_b     = lo[0] ? (last ? ~mcand : mcand) : '0;
    assign add_cin   = lo[0] & last;
    assign ovf       = (hi[W-1] == add_b[W-1]) & (sum[W-1] != hi[W-1]);
    assign shift_msb = sum[W-1] ^ ovf;
`else
    assign add_b     = lo[0] ? mcand : '0;
    assign add_cin   = 1'b0;
    assign shift_msb = cout;
`endif

    cla_add16 u_add (
        .x    (hi),
        .y    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        lo    <= b;
                        hi    <= '0;
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    {hi, lo} <= {shift_msb, sum, lo[W-1:1]};
                    count    <= count + CNT_W'(1);
                    if (last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign p         = {hi, lo};

endmodule
